cpu_clk_ctrl: RTL

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/cpu_clk_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 62 ++++++
 rtl/cpu_clk_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cpu_clk_pkg.sv
// Purpose: shared mode and FSM state encodings for the CPU clock controller.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package cpu_clk_pkg;

    // Operator mode selector; both 00 and 11 mean halt.
    localparam logic [1:0] MODE_HALT     = 2'b00;
    localparam logic [1:0] MODE_RUN      = 2'b01;
    localparam logic [1:0] MODE_STEP     = 2'b10;
    localparam logic [1:0] MODE_HALT_ALT = 2'b11;

    // Controller states; the encoding is exported on the state port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    function automatic logic is_halt_mode(input logic [1:0] m);
        return (m == MODE_HALT) || (m == MODE_HALT_ALT);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose: synchronise, debounce and rising-edge detect a raw pushbutton.
// Latency: o_step_req pulses 2 + DEB_N cycles after a clean press reaches i_btn.
// Backpressure: none; a pulse not consumed in its cycle is lost.
//
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_btn      raw asynchronous button level
//   o_step_req one-cycle pulse per debounced 0->1 transition
module btn_debounce #(
    parameter int unsigned DEB_N = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_step_req
);

    localparam int unsigned      CNT_W   = (DEB_N > 1) ? $clog2(DEB_N) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_N - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_step_req;

    logic w_diff;
    logic w_flip;

    // r_cnt holds how many consecutive cycles the synchronised input has
    // already disagreed with r_deb; the DEB_N-th disagreeing cycle flips it.
    assign w_diff = r_sync2 ^ r_deb;
    assign w_flip = w_diff && (r_cnt == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_deb      <= 1'b0;
            r_cnt      <= '0;
            r_step_req <= 1'b0;
        end else begin
            r_sync1    <= i_btn;
            r_sync2    <= r_sync1;
            // Pulse in the same cycle the debounced level first reads 1.
            r_step_req <= w_flip && !r_deb;
            if (w_flip) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                // Any bounce back to the current level restarts the count.
                r_cnt <= '0;
            end
        end
    end

    assign o_step_req = r_step_req;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Purpose: CPU clock-enable generator with run / single-step / halt control.
// Latency: cpu_ce is registered, one cycle after the qualifying scan_tick or step_req.
// Backpressure: none; step requests outside STEP are dropped, never queued.
//
// Ports:
//   CLK_100mhz  system clock (only clock)
//   Reset       synchronous active-high reset
//   mode        00/11 halt, 01 run, 10 single step
//   step_btn    raw step pushbutton
//   halt_req    CPU halt-instruction level
//   cpu_ce      one-cycle CPU clock-enable pulse
//   scan_tick   free-running pulse every DIV_N cycles
//   state       current FSM state encoding
//   step_count  cpu_ce pulses issued since reset (wraps)
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DIV_N = 50000,
    parameter int unsigned DEB_N = 1000000
) (
    input  logic        CLK_100mhz,
    input  logic        Reset,
    input  logic [1:0]  mode,
    input  logic        step_btn,
    input  logic        halt_req,
    output logic        cpu_ce,
    output logic        scan_tick,
    output logic [1:0]  state,
    output logic [31:0] step_count
);

    localparam logic [31:0] DIV_MAX = 32'(DIV_N - 1);

    logic [31:0] r_div;
    logic        r_scan_tick;
    logic        r_cpu_ce;
    logic [31:0] r_step_count;
    state_t      r_state;

    logic [31:0] w_div_nxt;
    state_t      w_state_nxt;
    logic        w_ce_nxt;
    logic        w_step_req;

    btn_debounce #(
        .DEB_N (DEB_N)
    ) u_btn_debounce (
        .i_clk      (CLK_100mhz),
        .i_rst      (Reset),
        .i_btn      (step_btn),
        .o_step_req (w_step_req)
    );

    // Divider: scan_tick is registered from the next count so that it is high
    // exactly while the counter holds DIV_N-1.
    assign w_div_nxt = (r_div == DIV_MAX) ? 32'd0 : r_div + 32'd1;

    always_ff @(posedge CLK_100mhz) begin
        if (Reset) begin
            r_div       <= 32'd0;
            r_scan_tick <= 1'b0;
        end else begin
            r_div       <= w_div_nxt;
            r_scan_tick <= (w_div_nxt == DIV_MAX);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ce_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // halt_req is deliberately not looked at here.
                if (mode == MODE_RUN) begin
                    w_state_nxt = ST_RUN;
                end else if (mode == MODE_STEP) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                w_ce_nxt = r_scan_tick;
                if (halt_req) begin
                    w_state_nxt = ST_HALTED;
                end else if (mode == MODE_STEP) begin
                    w_state_nxt = ST_STEP;
                end else if (mode != MODE_RUN) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STEP: begin
                w_ce_nxt = w_step_req;
                if (halt_req) begin
                    w_state_nxt = ST_HALTED;
                end else if (mode == MODE_RUN) begin
                    w_state_nxt = ST_RUN;
                end else if (mode != MODE_STEP) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (is_halt_mode(mode)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A same-cycle halt beats the pending enable. The r_cpu_ce term stops
        // back-to-back pulses when a RUN tick is followed by a STEP request
        // right after a mode switch.
        if (halt_req || r_cpu_ce) begin
            w_ce_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK_100mhz) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_cpu_ce     <= 1'b0;
            r_step_count <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cpu_ce <= w_ce_nxt;
            // Counted on the same edge as the pulse, so step_count already
            // includes the pulse currently on cpu_ce.
            if (w_ce_nxt) begin
                r_step_count <= r_step_count + 32'd1;
            end
        end
    end

    assign cpu_ce     = r_cpu_ce;
    assign scan_tick  = r_scan_tick;
    assign state      = r_state;
    assign step_count = r_step_count;

endmodule
